four_bit_seq_divider: RTL

Sequential restoring divider: the inverse of the team's four-bit ripple add/subtract datapath. It accepts an unsigned dividend and divisor with a start pulse. It performs one shift-and-subtract step per clock and returns the quotient and remainder with a done pulse. It sits beside the adder/subtractor in the arithmetic datapath as the multi-cycle divide unit.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_sub_step.sv | 41 ++++
 rtl/four_bit_seq_divider.sv | 130 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider.
//   DIV_W       : default operand / quotient / remainder width.
//   div_state_t : controller states (IDLE, BUSY, DONE).
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage : div_pkg

// File: rtl/div_sub_step.sv
// -----------------------------------------------------------------------------
// div_sub_step
// (W+1)-bit ripple subtractor used for one restoring-division step.
// Computes diff = a - b as a + ~b + 1 through a chain of one-bit full adders.
// carry_out is 1 when no borrow occurred, i.e. a >= b.
// Ports:
//   a         in  W+1  minuend (shifted partial remainder)
//   b         in  W+1  subtrahend (zero-extended divisor)
//   diff      out W+1  a - b, modulo 2^(W+1)
//   carry_out out 1    1 = no borrow, the subtraction is kept
// -----------------------------------------------------------------------------
module div_sub_step
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W:0] a,
    input  logic [W:0] b,
    output logic [W:0] diff,
    output logic       carry_out
);

    logic [W:0]   b_inv;
    logic [W+1:0] carry;

    // Subtraction as addition of the one's complement with carry-in 1.
    assign b_inv    = ~b;
    assign carry[0] = 1'b1;

    // One full adder per bit; the carry ripples from LSB to MSB.
    genvar i;
    generate
        for (i = 0; i <= W; i++) begin : g_fa
            assign diff[i]      = a[i] ^ b_inv[i] ^ carry[i];
            assign carry[i + 1] = (a[i] & b_inv[i]) | (carry[i] & (a[i] ^ b_inv[i]));
        end
    endgenerate

    assign carry_out = carry[W + 1];

endmodule : div_sub_step

// File: rtl/four_bit_seq_divider.sv
// -----------------------------------------------------------------------------
// four_bit_seq_divider
// Multi-cycle unsigned restoring divider: one shift-and-subtract step per
// clock. A divide of nonzero divisor takes W BUSY cycles plus one DONE cycle;
// a zero divisor goes straight to DONE with a saturated quotient.
// Ports:
//   clk         in  1  rising-edge clock
//   rst         in  1  asynchronous active-high reset
//   start       in  1  divide request, only looked at in IDLE
//   dividend    in  W  unsigned dividend, captured with start
//   divisor     in  W  unsigned divisor, captured with start
//   busy        out 1  high while the controller is not IDLE
//   done        out 1  single-cycle pulse, results valid in this cycle
//   quotient    out W  result quotient, held until overwritten by the next result
//   remainder   out W  result remainder, held like quotient
//   div_by_zero out 1  set with done for a zero divisor, cleared at next accept
// -----------------------------------------------------------------------------
module four_bit_seq_divider
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(W + 1);

    div_state_t    state;
    logic [W:0]    p_reg;
    logic [W-1:0]  q_reg;
    logic [W-1:0]  d_reg;
    logic [CW-1:0] step_cnt;

    logic [W:0]    t_val;
    logic [W:0]    sub_diff;
    logic          sub_carry;
    logic [W:0]    next_p;
    logic [W-1:0]  next_q;

    // Shift the next dividend bit into the partial remainder before subtracting.
    assign t_val = {p_reg[W-1:0], q_reg[W-1]};

    div_sub_step #(
        .W (W)
    ) u_sub (
        .a         (t_val),
        .b         ({1'b0, d_reg}),
        .diff      (sub_diff),
        .carry_out (sub_carry)
    );

    // Restore on borrow: keep the shifted value, shift a 0 into the quotient.
    assign next_p = sub_carry ? sub_diff : t_val;
    assign next_q = {q_reg[W-2:0], sub_carry};

    // Controller, datapath registers and registered outputs. Results are only
    // written on the transition into DONE, so a reset mid-divide never exposes
    // a partial quotient.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            p_reg       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            step_cnt    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        p_reg       <= '0;
                        q_reg       <= dividend;
                        d_reg       <= divisor;
                        step_cnt    <= '0;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end

                BUSY: begin
                    p_reg    <= next_p;
                    q_reg    <= next_q;
                    step_cnt <= step_cnt + CW'(1);
                    // The final step lands its result directly in the outputs.
                    if (step_cnt == CW'(W - 1)) begin
                        quotient  <= next_q;
                        remainder <= next_p[W-1:0];
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule : four_bit_seq_divider
